// File: rtl/fp_add_pipe.sv
// Four-stage pipelined IEEE-754 adder/subtractor with valid/ready flow control on both sides.
// Define FP_ADD_PIPE_RNE_EN for round-to-nearest-even; by default results truncate toward zero.
module fp_add_pipe #(
    parameter  int EXP_SIZE  = 8,
    parameter  int FRAC_SIZE = 23,
    localparam int FP_SIZE   = 1 + EXP_SIZE + FRAC_SIZE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FP_SIZE-1:0] a,
    input  logic [FP_SIZE-1:0] b,
    input  logic               op_sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FP_SIZE-1:0] result,
    output logic               flag_zero,
    output logic               flag_ovf,
    output logic               flag_inexact,
    output logic               flag_nan
);
    localparam int E   = EXP_SIZE;
    localparam int F   = FRAC_SIZE;
    localparam int W   = F + 4;            // hidden bit, fraction, guard, round, sticky
    localparam int LZW = $clog2(W + 1);
    localparam int XW  = E + LZW;
    localparam logic [E-1:0] EXP_ONES = '1;
    localparam logic [E-1:0] EXP_MAX  = {{(E-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {K_NORM, K_ZERO, K_INF, K_NAN} kind_e;

    // Flow control: one global stall freezes every stage, bubbles included.
    logic stall, advance;
    assign stall    = out_valid && !out_ready;
    assign advance  = !stall;
    assign in_ready = advance;

    // ---------------- S1: unpack, classify, swap ----------------
    logic         sign_a, sign_b;
    logic [E-1:0] exp_a, exp_b;
    logic [F-1:0] frac_a, frac_b;
    logic [W-1:0] sig_a, sig_b;
    logic         inf_a, inf_b, nan_a, nan_b, swap;

    assign sign_a = a[FP_SIZE-1];
    assign sign_b = b[FP_SIZE-1] ^ op_sub;
    assign exp_a  = a[FP_SIZE-2 -: E];
    assign exp_b  = b[FP_SIZE-2 -: E];
    // A zero exponent flushes the stored fraction, so denormals behave as signed zero.
    assign frac_a = (exp_a == '0) ? '0 : a[F-1:0];
    assign frac_b = (exp_b == '0) ? '0 : b[F-1:0];
    assign sig_a  = {exp_a != '0, frac_a, 3'b000};
    assign sig_b  = {exp_b != '0, frac_b, 3'b000};
    assign inf_a  = (exp_a == EXP_ONES) && (frac_a == '0);
    assign inf_b  = (exp_b == EXP_ONES) && (frac_b == '0);
    assign nan_a  = (exp_a == EXP_ONES) && (frac_a != '0);
    assign nan_b  = (exp_b == EXP_ONES) && (frac_b != '0);
    assign swap   = {exp_b, frac_b} > {exp_a, frac_a};

    logic         s1_valid, s1_sign, s1_eff_sub;
    logic [E-1:0] s1_exp, s1_diff;
    logic [W-1:0] s1_sig_x, s1_sig_y;
    kind_e        s1_kind;

    // NOTE: stage data registers carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (advance && in_valid) begin
            s1_eff_sub <= sign_a ^ sign_b;
            if (nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b)))
                s1_kind <= K_NAN;
            else if (inf_a || inf_b)
                s1_kind <= K_INF;
            else
                s1_kind <= K_NORM;
            if (inf_a || inf_b)
                s1_sign <= inf_a ? sign_a : sign_b;
            else
                s1_sign <= swap ? sign_b : sign_a;
            s1_exp   <= swap ? exp_b : exp_a;
            s1_diff  <= swap ? (exp_b - exp_a) : (exp_a - exp_b);
            s1_sig_x <= swap ? sig_b : sig_a;
            s1_sig_y <= swap ? sig_a : sig_b;
        end
    end

    // ---------------- S2: align and add ----------------
    logic [W-1:0] y_shift, y_align;
    logic         y_lost;
    logic [W:0]   sum;

    // NOTE: every variable gets a value on every path, so no latch is inferred.
    always_comb begin
        y_shift = s1_sig_y >> s1_diff;
        y_lost  = |(s1_sig_y & ~({W{1'b1}} << s1_diff));
        if (int'(s1_diff) >= F + 3)
            y_align = W'(|s1_sig_y);
        else
            y_align = y_shift | W'(y_lost);
        if (s1_eff_sub)
            sum = {1'b0, s1_sig_x} - {1'b0, y_align};
        else
            sum = {1'b0, s1_sig_x} + {1'b0, y_align};
    end

    logic         s2_valid, s2_sign, s2_eff_sub;
    logic [E-1:0] s2_exp;
    logic [W:0]   s2_sum;
    kind_e        s2_kind;

    always_ff @(posedge clk) begin
        if (advance && s1_valid) begin
            s2_sign    <= s1_sign;
            s2_eff_sub <= s1_eff_sub;
            s2_exp     <= s1_exp;
            s2_sum     <= sum;
            s2_kind    <= s1_kind;
        end
    end

    // ---------------- S3: normalise ----------------
    function automatic logic [LZW-1:0] lzc(input logic [W-1:0] v);
        lzc = LZW'(W);
        for (int i = 0; i < W; i++)
            if (v[i]) lzc = LZW'(W - 1 - i);
    endfunction

    logic [LZW-1:0] lz;
    logic [W-1:0]   norm_mant;
    logic [E:0]     norm_exp;
    logic           norm_sign, norm_flush;
    kind_e          norm_kind;

    always_comb begin
        lz         = lzc(s2_sum[W-1:0]);
        norm_mant  = s2_sum[W-1:0] << lz;
        norm_exp   = {1'b0, s2_exp} - (E+1)'(lz);
        norm_sign  = s2_sign;
        norm_flush = 1'b0;
        norm_kind  = s2_kind;
        if (s2_kind == K_NORM) begin
            if (s2_sum[W]) begin
                norm_mant = s2_sum[W:1] | W'(s2_sum[0]);
                norm_exp  = {1'b0, s2_exp} + 1'b1;
            end else if (s2_sum == '0) begin
                // Exact cancellation gives +0; only like-signed zeros keep their sign.
                norm_kind = K_ZERO;
                norm_sign = s2_sign & ~s2_eff_sub;
            end else if (XW'(s2_exp) <= XW'(lz)) begin
                norm_kind  = K_ZERO;
                norm_flush = 1'b1;
            end
        end
    end

    logic         s3_valid, s3_sign, s3_flush;
    logic [E:0]   s3_exp;
    logic [W-1:0] s3_mant;
    kind_e        s3_kind;

    always_ff @(posedge clk) begin
        if (advance && s2_valid) begin
            s3_sign  <= norm_sign;
            s3_flush <= norm_flush;
            s3_exp   <= norm_exp;
            s3_mant  <= norm_mant;
            s3_kind  <= norm_kind;
        end
    end

    // ---------------- S4: round and pack ----------------
    logic               round_up, ovf;
    logic [F+1:0]       rounded;
    logic [E:0]         rexp;
    logic [F-1:0]       rfrac;
    logic [FP_SIZE-1:0] pack;
    logic               pk_zero, pk_ovf, pk_inexact, pk_nan;

`ifdef FP_ADD_PIPE_RNE_EN
    assign round_up = s3_mant[2] & (s3_mant[1] | s3_mant[0] | s3_mant[3]);
`else
    assign round_up = 1'b0;
`endif
    assign rounded = {1'b0, s3_mant[W-1:3]} + (F+2)'(round_up);
    assign rexp    = rounded[F+1] ? (s3_exp + 1'b1) : s3_exp;
    assign rfrac   = rounded[F+1] ? rounded[F:1] : rounded[F-1:0];
    assign ovf     = rexp >= {1'b0, EXP_ONES};

    always_comb begin
        pack       = '0;
        pk_zero    = 1'b0;
        pk_ovf     = 1'b0;
        pk_inexact = 1'b0;
        pk_nan     = 1'b0;
        unique case (s3_kind)
            K_NAN: begin
                pack   = {1'b0, EXP_ONES, 1'b1, {(F-1){1'b0}}};
                pk_nan = 1'b1;
            end
            K_INF: pack = {s3_sign, EXP_ONES, {F{1'b0}}};
            K_ZERO: begin
                pack       = {s3_sign, {(FP_SIZE-1){1'b0}}};
                pk_zero    = 1'b1;
                pk_inexact = s3_flush;
            end
            default: begin
                pk_inexact = |s3_mant[2:0];
                if (ovf) begin
                    pk_ovf     = 1'b1;
                    pk_inexact = 1'b1;
`ifdef FP_ADD_PIPE_RNE_EN
                    pack = {s3_sign, EXP_ONES, {F{1'b0}}};
`else
                    pack = {s3_sign, EXP_MAX, {F{1'b1}}};
`endif
                end else begin
                    pack = {s3_sign, rexp[E-1:0], rfrac};
                end
            end
        endcase
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s2_valid     <= 1'b0;
            s3_valid     <= 1'b0;
            out_valid    <= 1'b0;
            result       <= '0;
            flag_zero    <= 1'b0;
            flag_ovf     <= 1'b0;
            flag_inexact <= 1'b0;
            flag_nan     <= 1'b0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            s3_valid  <= s2_valid;
            out_valid <= s3_valid;
            if (s3_valid) begin
                result       <= pack;
                flag_zero    <= pk_zero;
                flag_ovf     <= pk_ovf;
                flag_inexact <= pk_inexact;
                flag_nan     <= pk_nan;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed self-checking bench for fp_add_pipe (binary32): arithmetic vectors, specials,
// backpressure and mid-flight reset. Expected values follow FP_ADD_PIPE_RNE_EN when defined.
module tb_fp_add_pipe;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, op_sub, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic        flag_zero, flag_ovf, flag_inexact, flag_nan;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fp_add_pipe dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .op_sub       (op_sub),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .flag_zero    (flag_zero),
        .flag_ovf     (flag_ovf),
        .flag_inexact (flag_inexact),
        .flag_nan     (flag_nan)
    );

`ifdef FP_ADD_PIPE_RNE_EN
    localparam logic [31:0] EXP_ROUND = 32'h3F800001;
    localparam logic [31:0] EXP_OVF   = 32'h7F800000;
`else
    localparam logic [31:0] EXP_ROUND = 32'h3F800000;
    localparam logic [31:0] EXP_OVF   = 32'h7F7FFFFF;
`endif
    localparam logic [31:0] ONE = 32'h3F800000;

    // flags packed as {zero, ovf, inexact, nan}
    typedef struct {
        string       tag;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic [3:0]  fl;
    } vec_t;

    vec_t vecs[$];

    // stream operands 1.0 .. 8.0, each plus 1.0
    logic [31:0] st_a[8]   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] st_res[8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                               32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic add_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                           input logic vs, input logic [31:0] vr, input logic [3:0] vf);
        vec_t v;
        v.tag = tag; v.a = va; v.b = vb; v.sub = vs; v.res = vr; v.fl = vf;
        vecs.push_back(v);
    endtask

    // Called at a negedge with an idle pipeline; checks latency, result and flags.
    task automatic run_op(input vec_t v);
        int edges;
        in_valid  = 1'b1;
        a         = v.a;
        b         = v.b;
        op_sub    = v.sub;
        out_ready = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({v.tag, "_latency"}, 64'(edges), 64'd4);
        check({v.tag, "_result"}, 64'(result), 64'(v.res));
        check({v.tag, "_flags"}, 64'({flag_zero, flag_ovf, flag_inexact, flag_nan}), 64'(v.fl));
    endtask

    initial begin : main
        int   tx, rx, seen;
        logic accept;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op_sub = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'({flag_zero, flag_ovf, flag_inexact, flag_nan}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        add_vec("add_1_2",      32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
        add_vec("sub_1_1",      32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b1000);
        add_vec("sub_lzc23",    32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 4'b0000);
        add_vec("round",        32'h3F800000, 32'h33C00000, 1'b0, EXP_ROUND,     4'b0010);
        add_vec("ovf",          32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, EXP_OVF,       4'b0110);
        add_vec("inf_sub_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b0001);
        add_vec("negz_negz",    32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b1000);
        add_vec("add_1_neg2",   32'h3F800000, 32'hC0000000, 1'b0, 32'hBF800000, 4'b0000);
        add_vec("carry_3",      32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 4'b0000);
        add_vec("inf_add_1",    32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000);
        add_vec("one_sub_inf",  32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000);
        add_vec("nan_add_1",    32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0001);
        add_vec("denorm_flush", 32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 4'b1000);
        add_vec("underflow",    32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b1010);

        foreach (vecs[i]) run_op(vecs[i]);

        // drain the last presented result
        @(posedge clk);
        @(negedge clk);

        // Backpressure: 8 back-to-back adds, consumer blocked for the first 10 cycles.
        tx = 0;
        rx = 0;
        for (int t = 0; t < 100 && rx < 8; t++) begin
            out_ready = (t >= 10);
            in_valid  = (tx < 8);
            a         = (tx < 8) ? st_a[tx] : '0;
            b         = ONE;
            op_sub    = 1'b0;
            #1;
            if (out_valid && out_ready) begin
                check($sformatf("stream_result_%0d", rx), 64'(result), 64'(st_res[rx]));
                rx++;
            end else if (out_valid) begin
                check($sformatf("stall_result_t%0d", t), 64'(result), 64'(st_res[rx]));
                check($sformatf("stall_in_ready_t%0d", t), 64'(in_ready), 64'd0);
            end
            accept = in_valid && in_ready;
            @(posedge clk);
            if (accept) tx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("stream_count", 64'(rx), 64'd8);
        check("stream_sent", 64'(tx), 64'd8);

        // Reset with three operations in flight plus one presented on the reset cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = st_a[i];
            b        = ONE;
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        a   = st_a[3];
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_result", 64'(result), 64'd0);
        check("mid_rst_flags", 64'({flag_zero, flag_ovf, flag_inexact, flag_nan}), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mid_rst_no_stale", 64'(seen), 64'd0);

        // pipeline still works after the reset
        run_op(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
